// File: rtl/ifft_pkg.sv
// rtl/ifft_pkg.sv - shared sizes, FSM state encoding and bit-reverse helper for the 16-point IFFT controller
package ifft_pkg;

    localparam int N_PTS    = 16;
    localparam int N_STAGES = 4;
    localparam int ADDR_W   = 4;
    localparam int TW_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        DRAIN,
        UNLOAD
    } state_t;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = x[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ifft_ctrl_if.sv
// rtl/ifft_ctrl_if.sv - handshake, RAM address and status bundle between the IFFT controller and its datapath
interface ifft_ctrl_if;
    import ifft_pkg::*;

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [TW_W-1:0]   tw_idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [1:0]        stage;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, ld_addr, rd_addr_a, rd_addr_b, tw_idx,
               wr_en, wr_addr_a, wr_addr_b, stage,
               out_valid, out_addr, busy, done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, ld_addr, rd_addr_a, rd_addr_b, tw_idx,
               wr_en, wr_addr_a, wr_addr_b, stage,
               out_valid, out_addr, busy, done
    );

endinterface

// File: rtl/ifft_addr_gen.sv
// rtl/ifft_addr_gen.sv - combinational (stage, butterfly) to operand address and twiddle index mapping
module ifft_addr_gen
    import ifft_pkg::*;
(
    input  logic [$clog2(N_STAGES)-1:0] stage,
    input  logic [2:0]                  k,
    output logic [ADDR_W-1:0]           rd_addr_a,
    output logic [ADDR_W-1:0]           rd_addr_b,
    output logic [TW_W-1:0]             tw_idx
);

    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] kk;
    logic [ADDR_W-1:0] idx;

    // span is a power of two, so k/span and k%span reduce to masking
    always_comb begin
        span      = ADDR_W'(N_PTS / 2) >> stage;
        mask      = span - 1'b1;
        kk        = {1'b0, k};
        idx       = kk & mask;
        rd_addr_a = ((kk & ~mask) << 1) | idx;
        rd_addr_b = rd_addr_a + span;
        tw_idx    = TW_W'(idx << stage);
    end

endmodule

// File: rtl/ifft_ctrl.sv
// rtl/ifft_ctrl.sv - 16-point radix-2 IFFT sequencer; IFFT_CTRL_BITREV_EN selects bit-reversed load addressing
module ifft_ctrl
    import ifft_pkg::*;
#(
    parameter int PIPE_LAT = 2,
    parameter int N_LOG2   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ifft_ctrl_if.master  bus
);

    localparam logic [1:0] LAST_STG = 2'(N_LOG2 - 1);
    localparam logic [2:0] LAST_K   = 3'(N_PTS / 2 - 1);
    localparam logic [2:0] PL       = 3'(PIPE_LAT);

    state_t            state;
    logic [ADDR_W-1:0] ld_cnt;
    logic [ADDR_W-1:0] out_cnt;
    logic [2:0]        k;
    logic [1:0]        stg;
    logic [2:0]        bub;
    logic              done_q;

    logic              issue;
    logic [ADDR_W-1:0] gen_a, gen_b, rd_a, rd_b;
    logic [TW_W-1:0]   gen_tw;

    logic              dl_en [PIPE_LAT];
    logic [ADDR_W-1:0] dl_a  [PIPE_LAT];
    logic [ADDR_W-1:0] dl_b  [PIPE_LAT];

    ifft_addr_gen u_addr_gen (
        .stage     (stg),
        .k         (k),
        .rd_addr_a (gen_a),
        .rd_addr_b (gen_b),
        .tw_idx    (gen_tw)
    );

    // bub counts down the read-after-write bubbles between stages and the final drain
    assign issue = (state == CALC) && (bub == '0);
    assign rd_a  = issue ? gen_a : '0;
    assign rd_b  = issue ? gen_b : '0;

    assign bus.in_ready  = (state == LOAD);
`ifdef IFFT_CTRL_BITREV_EN
    assign bus.ld_addr   = bitrev(ld_cnt);
`else
    assign bus.ld_addr   = ld_cnt;
`endif
    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.tw_idx    = issue ? gen_tw : '0;
    assign bus.wr_en     = dl_en[PIPE_LAT-1];
    assign bus.wr_addr_a = dl_a[PIPE_LAT-1];
    assign bus.wr_addr_b = dl_b[PIPE_LAT-1];
    assign bus.stage     = stg;
    assign bus.out_valid = (state == UNLOAD);
    assign bus.out_addr  = out_cnt;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ld_cnt  <= '0;
            out_cnt <= '0;
            k       <= '0;
            stg     <= '0;
            bub     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) state <= LOAD;
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        if (ld_cnt == ADDR_W'(N_PTS - 1)) state <= CALC;
                    end
                end
                CALC: begin
                    if (bub != '0) begin
                        bub <= bub - 1'b1;
                    end else if (k == LAST_K) begin
                        k <= '0;
                        if (stg == LAST_STG) begin
                            stg   <= '0;
                            bub   <= PL - 1'b1;
                            state <= DRAIN;
                        end else begin
                            stg <= stg + 1'b1;
                            bub <= PL;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bub == '0) state <= UNLOAD;
                    else           bub   <= bub - 1'b1;
                end
                UNLOAD: begin
                    if (bus.out_ready) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == ADDR_W'(N_PTS - 1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_en[i] <= 1'b0;
                dl_a[i]  <= '0;
                dl_b[i]  <= '0;
            end
        end else begin
            dl_en[0] <= issue;
            dl_a[0]  <= rd_a;
            dl_b[0]  <= rd_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_en[i] <= dl_en[i-1];
                dl_a[i]  <= dl_a[i-1];
                dl_b[i]  <= dl_b[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ifft_ctrl.sv
// tb/tb_ifft_ctrl.sv - randomized self-checking bench for ifft_ctrl against a schedule model
module tb_ifft_ctrl;
    import ifft_pkg::*;

    localparam int PL  = 2;
    localparam int TOT = 32 + 4 * PL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifft_ctrl_if bus();

    ifft_ctrl #(.PIPE_LAT(PL), .N_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [33:0] all_out();
        return {bus.in_ready, bus.ld_addr, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx,
                bus.wr_en, bus.wr_addr_a, bus.wr_addr_b, bus.stage,
                bus.out_valid, bus.out_addr, bus.busy, bus.done};
    endfunction

    function automatic logic [3:0] exp_ld(input int n);
        logic [3:0] v, r;
        v = 4'(n);
        for (int i = 0; i < 4; i++) r[i] = v[3-i];
`ifdef IFFT_CTRL_BITREV_EN
        return r;
`else
        return v;
`endif
    endfunction

    task automatic test_reset();
        bus.start = 0; bus.in_valid = 0; bus.out_ready = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_out() !== 34'h0) begin
            n_fail++; $display("FAIL reset_outputs got %h want 0", all_out());
        end
        rst_n = 1; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        n_cmp++;
        if ({bus.busy, bus.in_ready} !== 2'b11) begin
            n_fail++; $display("FAIL first_start got %b want 11", {bus.busy, bus.in_ready});
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if (all_out() !== 34'h0) begin
            n_fail++; $display("FAIL reset_in_load got %h want 0", all_out());
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic run_frame(input bit directed, input bit abort);
        int n, m, guard, wr_cnt, c, span, grp, idx;
        bit hs, we;
        bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit       e_iss [TOT];
        bit [3:0] e_a   [TOT];
        bit [3:0] e_b   [TOT];
        bit [2:0] e_tw  [TOT];
        bit [1:0] e_stg [TOT];

        c = 0;
        for (int s = 0; s < 4; s++) begin
            for (int kk = 0; kk < 8; kk++) begin
                span = 8 >> s; grp = kk / span; idx = kk % span;
                e_iss[c] = 1; e_stg[c] = 2'(s);
                e_a[c] = 4'(grp * 2 * span + idx);
                e_b[c] = 4'(grp * 2 * span + idx + span);
                e_tw[c] = 3'(idx << s);
                c++;
            end
            for (int j = 0; j < PL; j++) begin
                e_iss[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0;
                e_stg[c] = (s < 3) ? 2'(s + 1) : 2'd0;
                c++;
            end
        end

        @(negedge clk); bus.start = 1;
        @(negedge clk); bus.start = 0;

        n = 0; guard = 0;
        while (n < 16 && guard < 400) begin
            n_cmp++;
            if ({bus.in_ready, bus.busy, bus.ld_addr} !== {2'b11, exp_ld(n)}) begin
                n_fail++;
                $display("FAIL load[%0d] got rdy/busy/addr %b/%b/%h want 1/1/%h",
                         n, bus.in_ready, bus.busy, bus.ld_addr, exp_ld(n));
            end
            bus.in_valid = directed ? 1'b1 : ($urandom_range(3) != 0);
            bus.start    = directed ? 1'b0 : ($urandom_range(7) == 0);
            hs = bus.in_valid;
            @(posedge clk);
            if (hs) n++;
            guard++;
            @(negedge clk);
        end
        bus.in_valid = 0; bus.start = 0;
        if (n < 16) begin
            n_cmp++; n_fail++; $display("FAIL load_timeout got %0d want 16", n);
        end

        wr_cnt = 0;
        for (int t = 0; t < TOT; t++) begin
            if (abort && t == 2 * (8 + PL)) begin
                rst_n = 0;
                #1;
                n_cmp++;
                if (all_out() !== 34'h0) begin
                    n_fail++; $display("FAIL midframe_reset got %h want 0", all_out());
                end
                @(negedge clk);
                rst_n = 1;
                return;
            end
            n_cmp++;
            if (e_iss[t]) begin
                if ({bus.stage, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.in_ready, bus.out_valid, bus.busy}
                    !== {e_stg[t], e_a[t], e_b[t], e_tw[t], 3'b001}) begin
                    n_fail++;
                    $display("FAIL calc[%0d] got stg/a/b/tw %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                             t, bus.stage, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx,
                             e_stg[t], e_a[t], e_b[t], e_tw[t]);
                end
            end else if ({bus.stage, bus.in_ready, bus.out_valid, bus.busy} !== {e_stg[t], 3'b001}) begin
                n_fail++;
                $display("FAIL bubble[%0d] got stg/busy %0d/%b want %0d/1", t, bus.stage, bus.busy, e_stg[t]);
            end
            we = (t >= PL) && e_iss[t-PL];
            n_cmp++;
            if (bus.wr_en !== we) begin
                n_fail++; $display("FAIL wr_en[%0d] got %b want %b", t, bus.wr_en, we);
            end else if (we && {bus.wr_addr_a, bus.wr_addr_b} !== {e_a[t-PL], e_b[t-PL]}) begin
                n_fail++;
                $display("FAIL wr_addr[%0d] got %0d/%0d want %0d/%0d",
                         t, bus.wr_addr_a, bus.wr_addr_b, e_a[t-PL], e_b[t-PL]);
            end
            if (bus.wr_en === 1'b1) wr_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (wr_cnt != 32) begin
            n_fail++; $display("FAIL wr_en_count got %0d want 32", wr_cnt);
        end

        m = 0; guard = 0;
        while (m < 16 && guard < 400) begin
            n_cmp++;
            if ({bus.out_valid, bus.busy, bus.done, bus.in_ready, bus.out_addr} !== {4'b1100, 4'(m)}) begin
                n_fail++;
                $display("FAIL unload[%0d] got vld/busy/done/addr %b/%b/%b/%0d want 1/1/0/%0d",
                         m, bus.out_valid, bus.busy, bus.done, bus.out_addr, m);
            end
            bus.out_ready = (directed && guard < 4) ? rdy_pat[guard] : 1'($urandom_range(1));
            bus.start = (m == 15) && bus.out_ready;
            hs = bus.out_ready;
            @(posedge clk);
            if (hs) m++;
            guard++;
            @(negedge clk);
        end
        bus.out_ready = 0; bus.start = 0;
        if (m < 16) begin
            n_cmp++; n_fail++; $display("FAIL unload_timeout got %0d want 16", m);
        end
        n_cmp++;
        if ({bus.done, bus.busy, bus.out_valid} !== 3'b100) begin
            n_fail++; $display("FAIL done_pulse got done/busy/vld %b want 100", {bus.done, bus.busy, bus.out_valid});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL after_done got done/busy %b want 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_directed_frame();
        run_frame(1'b1, 1'b0);
    endtask

    task automatic test_random_frames();
        repeat (3) run_frame(1'b0, 1'b0);
    endtask

    task automatic test_midframe_reset();
        run_frame(1'b0, 1'b1);
        run_frame(1'b0, 1'b0);
    endtask

    initial begin
        bus.start = 0; bus.in_valid = 0; bus.out_ready = 0;
        test_reset();
        test_directed_frame();
        test_random_frames();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
